// File: rtl/reflet_float_op_sequencer_pkg.sv
// Shared definitions for the float op sequencer: opcode and FSM state encodings,
// counter width and the opcode-to-latency lookup.
package reflet_float_op_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  // ADD and SUB share a latency; the unit handles both in the same adder path.
  function automatic logic [CNT_W-1:0] opLatency(input op_t op,
                                                 input logic [CNT_W-1:0] addWait,
                                                 input logic [CNT_W-1:0] mulWait,
                                                 input logic [CNT_W-1:0] divWait);
    case (op)
      OP_MUL:  return mulWait;
      OP_DIV:  return divWait;
      default: return addWait;
    endcase
  endfunction

endpackage

// File: rtl/reflet_float_op_sequencer_if.sv
// Request/result handshake plus arithmetic-unit operand bus of the float op sequencer.
// slave is the sequencer's view; master is the surrounding system (requester and unit).
interface reflet_float_op_sequencer_if #(
  parameter int float_size = 16
);
  logic                  start;
  logic [1:0]            opcode;
  logic [float_size-1:0] op_a;
  logic [float_size-1:0] op_b;
  logic                  ack;
  logic                  busy;
  logic [float_size-1:0] result;
  logic                  valid;
  logic [float_size-1:0] unit_a;
  logic [float_size-1:0] unit_b;
  logic [1:0]            unit_op;
  logic [float_size-1:0] unit_result;

  modport slave (
    input  start, opcode, op_a, op_b, ack, unit_result,
    output busy, result, valid, unit_a, unit_b, unit_op
  );

  modport master (
    output start, opcode, op_a, op_b, ack, unit_result,
    input  busy, result, valid, unit_a, unit_b, unit_op
  );
endinterface

// File: rtl/reflet_float_latency_counter.sv
// Loadable 4-bit down-counter timing the arithmetic unit; o_done flags the last wait cycle.
module reflet_float_latency_counter
  import reflet_float_op_sequencer_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  // Load wins over decrement; the count saturates at zero instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_done = (r_count == CNT_W'(1));

endmodule

// File: rtl/reflet_float_op_sequencer.sv
// Sequences one floating-point operation at a time through an external combinational unit,
// waiting a per-opcode latency before capturing its result for the consumer.
module reflet_float_op_sequencer
  import reflet_float_op_sequencer_pkg::*;
#(
  parameter int float_size = 16,
  parameter int add_wait   = 1,
  parameter int mul_wait   = 2,
  parameter int div_wait   = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  reflet_float_op_sequencer_if.slave  bus
);

  state_t                r_state;
  state_t                w_nextState;
  logic                  w_accept;
  logic                  w_capture;
  logic                  w_release;
  logic                  w_cntDone;
  logic [CNT_W-1:0]      w_latency;
  logic [float_size-1:0] r_unitA;
  logic [float_size-1:0] r_unitB;
  logic [1:0]            r_unitOp;
  logic [float_size-1:0] r_result;
  logic                  r_valid;

  assign w_latency = opLatency(op_t'(bus.opcode), CNT_W'(add_wait),
                               CNT_W'(mul_wait), CNT_W'(div_wait));

  reflet_float_latency_counter u_counter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_accept),
    .i_dec   (r_state == ST_WAIT),
    .i_value (w_latency),
    .o_done  (w_cntDone)
  );

  // start is only looked at in IDLE, so a start coinciding with ack must be re-presented.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_nextState = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_cntDone) begin
          w_capture   = 1'b1;
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.ack) begin
          w_release   = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_unitA  <= '0;
      r_unitB  <= '0;
      r_unitOp <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_unitA  <= bus.op_a;
        r_unitB  <= bus.op_b;
        r_unitOp <= bus.opcode;
      end
      if (w_capture) begin
        r_result <= bus.unit_result;
        r_valid  <= 1'b1;
      end else if (w_release) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.busy    = (r_state != ST_IDLE);
  assign bus.valid   = r_valid;
  assign bus.result  = r_result;
  assign bus.unit_a  = r_unitA;
  assign bus.unit_b  = r_unitB;
  assign bus.unit_op = r_unitOp;

endmodule

// File: tb/tb_reflet_float_op_sequencer.sv
// Directed and randomized checks of reflet_float_op_sequencer with a behavioural arithmetic unit.
module tb_reflet_float_op_sequencer;

  logic clk;
  logic reset;
  int   checks = 0;
  int   passes = 0;

  reflet_float_op_sequencer_if #(.float_size(16)) bus ();

  reflet_float_op_sequencer #(
    .float_size (16),
    .add_wait   (1),
    .mul_wait   (2),
    .div_wait   (4)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in arithmetic unit; any distinct per-opcode mapping will do.
  function automatic logic [15:0] unitModel(input logic [15:0] a, input logic [15:0] b,
                                            input logic [1:0] op);
    case (op)
      2'd0:    return a ^ b ^ 16'h3E00;
      2'd1:    return a - b;
      2'd2:    return a * b;
      default: return a ^ ~b;
    endcase
  endfunction

  function automatic int expLatency(input logic [1:0] op);
    case (op)
      2'd2:    return 2;
      2'd3:    return 4;
      default: return 1;
    endcase
  endfunction

  assign bus.unit_result = unitModel(bus.unit_a, bus.unit_b, bus.unit_op);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    else passes++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request in IDLE and returns just after the accept edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.start  = 1'b1;
    bus.opcode = op;
    bus.op_a   = a;
    bus.op_b   = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Counts cycles including the accept cycle until valid rises; checks operands held meanwhile.
  task automatic waitValid(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                           input bit perturb, output int cycles);
    cycles = 1;
    while (!bus.valid && cycles < 40) begin
      checkOutput("busyWait", 32'(bus.busy), 32'd1);
      checkOutput("holdA", 32'(bus.unit_a), 32'(a));
      checkOutput("holdB", 32'(bus.unit_b), 32'(b));
      checkOutput("holdOp", 32'(bus.unit_op), 32'(op));
      if (perturb) begin
        bus.start  = 1'($urandom_range(0, 1));
        bus.opcode = 2'($urandom_range(0, 3));
        bus.op_a   = 16'($urandom);
        bus.op_b   = 16'($urandom);
      end
      tick();
      cycles++;
    end
    bus.start = 1'b0;
  endtask

  task automatic ackResult(input bit withStart);
    bus.ack   = 1'b1;
    bus.start = withStart;
    tick();
    bus.ack   = 1'b0;
    bus.start = 1'b0;
    checkOutput("validAfterAck", 32'(bus.valid), 32'd0);
    checkOutput("busyAfterAck", 32'(bus.busy), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_valid"}, 32'(bus.valid), 32'd0);
    checkOutput({tag, "_result"}, 32'(bus.result), 32'd0);
    checkOutput({tag, "_unitA"}, 32'(bus.unit_a), 32'd0);
    checkOutput({tag, "_unitB"}, 32'(bus.unit_b), 32'd0);
    checkOutput({tag, "_unitOp"}, 32'(bus.unit_op), 32'd0);
  endtask

  initial begin
    int          cyc;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.opcode = 2'd0;
    bus.op_a   = 16'h0;
    bus.op_b   = 16'h0;
    bus.ack    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    checkAllZero("reset");

    // ADD with default latency
    applyStimulus(2'd0, 16'h3C00, 16'h4000);
    waitValid(16'h3C00, 16'h4000, 2'd0, 1'b0, cyc);
    checkOutput("addLatency", 32'(cyc), 32'd2);
    checkOutput("addResult", 32'(bus.result), 32'h4200);
    checkOutput("addBusyDone", 32'(bus.busy), 32'd1);
    ackResult(1'b0);

    // DIV: longest default latency
    applyStimulus(2'd3, 16'h4400, 16'h4000);
    waitValid(16'h4400, 16'h4000, 2'd3, 1'b0, cyc);
    checkOutput("divLatency", 32'(cyc), 32'd5);
    checkOutput("divResult", 32'(bus.result), 32'(unitModel(16'h4400, 16'h4000, 2'd3)));
    ackResult(1'b0);

    // start during WAIT with other operands must not disturb the running MUL
    applyStimulus(2'd2, 16'h1234, 16'h0056);
    bus.start  = 1'b1;
    bus.opcode = 2'd1;
    bus.op_a   = 16'hBEEF;
    bus.op_b   = 16'hCAFE;
    tick();
    bus.start = 1'b0;
    checkOutput("midStartHoldA", 32'(bus.unit_a), 32'h1234);
    waitValid(16'h1234, 16'h0056, 2'd2, 1'b0, cyc);
    checkOutput("midStartLatency", 32'(cyc), 32'd2);
    checkOutput("midStartResult", 32'(bus.result), 32'(unitModel(16'h1234, 16'h0056, 2'd2)));
    ackResult(1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("noSecondValid", 32'(bus.valid), 32'd0);
    end

    // long DONE hold, then ack together with start
    applyStimulus(2'd1, 16'h5000, 16'h1000);
    waitValid(16'h5000, 16'h1000, 2'd1, 1'b0, cyc);
    checkOutput("subLatency", 32'(cyc), 32'd2);
    for (int i = 0; i < 10; i++) begin
      checkOutput("holdValid", 32'(bus.valid), 32'd1);
      checkOutput("holdResult", 32'(bus.result), 32'h4000);
      tick();
    end
    bus.opcode = 2'd2;
    bus.op_a   = 16'h7777;
    bus.op_b   = 16'h8888;
    ackResult(1'b1);
    tick();
    checkOutput("ackStartIgnored", 32'(bus.busy), 32'd0);
    checkOutput("ackStartUnitA", 32'(bus.unit_a), 32'h5000);

    // reset in the middle of a MUL wait
    applyStimulus(2'd2, 16'h0101, 16'h0202);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkAllZero("midReset");
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("noValidAfterReset", 32'(bus.valid), 32'd0);
    end
    applyStimulus(2'd0, 16'h2468, 16'h1357);
    waitValid(16'h2468, 16'h1357, 2'd0, 1'b0, cyc);
    checkOutput("postResetLatency", 32'(cyc), 32'd2);
    checkOutput("postResetResult", 32'(bus.result), 32'(unitModel(16'h2468, 16'h1357, 2'd0)));
    ackResult(1'b0);

    // random opcode mix against the latency/data reference
    for (int n = 0; n < 1000; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = 16'($urandom);
      b  = 16'($urandom);
      applyStimulus(op, a, b);
      waitValid(a, b, op, 1'b1, cyc);
      checkOutput("rndLatency", 32'(cyc), 32'(expLatency(op) + 1));
      checkOutput("rndResult", 32'(bus.result), 32'(unitModel(a, b, op)));
      for (int d = $urandom_range(0, 2); d > 0; d--) begin
        tick();
        checkOutput("rndHold", 32'(bus.valid), 32'd1);
      end
      ackResult(1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/reflet_float_op_sequencer.md
REFLET_FLOAT_OP_SEQUENCER -- requirements
Module: reflet_float_op_sequencer

Interface
REQ-001 Parameter float_size, default 16: width of operands and result in bits.
REQ-002 Parameter add_wait, default 1: cycles from operand launch to valid result for opcodes ADD/SUB; range 1..15.
REQ-003 Parameter mul_wait, default 2: cycles from operand launch to valid result for opcode MUL; range 1..15.
REQ-004 Parameter div_wait, default 4: cycles from operand launch to valid result for opcode DIV; range 1..15.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request pulse or level; sampled only in IDLE.
REQ-008 opcode  input  2  0=ADD, 1=SUB, 2=MUL, 3=DIV.
REQ-009 op_a, op_b  input  float_size  operands, captured on accept.
REQ-010 unit_a, unit_b  output  float_size  registered operands driven to the arithmetic unit.
REQ-011 unit_op  output  2  registered opcode driven to the arithmetic unit.
REQ-012 unit_result  input  float_size  combinational result returned by the arithmetic unit.
REQ-013 busy  output  1  high in WAIT and DONE.
REQ-014 result  output  float_size  captured result, stable while valid.
REQ-015 valid  output  1  result available.
REQ-016 ack  input  1  consumer has taken result; meaningful only while valid.

Function
REQ-017 FSM states: IDLE, WAIT, DONE.
REQ-018 IDLE and start=1: latch op_a, op_b and opcode into unit_a, unit_b and unit_op; load counter with the opcode latency (add_wait, mul_wait or div_wait); enter WAIT next cycle.
REQ-019 WAIT: decrement counter each cycle; unit_a, unit_b and unit_op are held constant.
REQ-020 WAIT with counter=1: capture unit_result into result, set valid, enter DONE. Total latency from the start-accept edge to valid high is exactly N+1 cycles, where N is the selected latency.
REQ-021 DONE: result and valid held until ack=1; on the ack edge clear valid and return to IDLE.
REQ-022 DONE with ack=1 and start=1 in the same cycle: ack is consumed; start is ignored and must be re-presented in IDLE. No back-to-back accept.
REQ-023 start while busy=1 is ignored with no side effects.
REQ-024 ack while valid=0 is ignored.
REQ-025 Counter width is 4 bits; it never underflows; it is reloaded only on accept.
REQ-026 unit_a, unit_b and unit_op retain their last values in IDLE and DONE, so no spurious operand change reaches the unit.
REQ-027 opcode, op_a and op_b changing during WAIT has no effect.

Reset
REQ-028 On reset=1 at a clock edge: state IDLE, counter 0, valid 0, busy 0, result 0, unit_a 0, unit_b 0, unit_op 0.
REQ-029 Reset dominates all inputs, including mid-WAIT and mid-DONE; any in-flight operation is discarded and no valid is produced.

Structure
REQ-030 The opcode encodings (ADD/SUB/MUL/DIV) and the state encodings are defined in the shared reflet_float definitions include file, not locally.
REQ-031 One sub-module, reflet_float_latency_counter, contains the loadable 4-bit down-counter with a load input, a value input and a done flag (counter=1); the FSM stays in the top module.

Verification
REQ-032 The bench covers each of the following directed scenarios:
- Default parameters; start with opcode=ADD, op_a=16'h3C00, op_b=16'h4000, unit model returns 16'h4200 -> valid high 2 cycles after accept, result=16'h4200, busy high throughout.
- opcode=DIV with div_wait=4 -> valid exactly 5 cycles after accept; unit_a and unit_b constant over all WAIT cycles.
- start pulsed during WAIT with different operands -> unit_a unchanged, no second valid, first result delivered.
- ack held low for 10 cycles in DONE -> valid and result stable for all 10 cycles; ack=1 -> valid 0 and IDLE next cycle; ack and start together -> new op not accepted.
- reset asserted during WAIT of a MUL -> all outputs 0 the next cycle, valid never rises; a following ADD completes normally.
- Random opcode mix over 1000 operations against a reference latency model -> zero latency or data mismatches.
